fifo_thresh: RTL and testbench
==============================

# fifo_thresh

Buffer FIFO with programmable almost-full/almost-empty flags: the consumer side of the threshold-configuration interface. It stores 12-bit words ([11:10] class, [9:8] destination, [7:0] data) and registers `full_threshold`/`empty_threshold` values supplied by the control state machine. It returns `empty` to that state machine; the nine instances' `empty` bits are concatenated into its 9-bit `fifos_empty` input.

## Interface
- `WORD_SIZE`, 12, width of one stored word
- `MEM_SIZE`, 8, depth in words
- `PTR`, 3, pointer width, log2(MEM_SIZE)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low
- `wr_enable`  in  1  write request
- `data_in`  in  WORD_SIZE  word to write
- `rd_enable`  in  1  read request
- `full_threshold`  in  PTR  almost-full level, sampled every cycle
- `empty_threshold`  in  PTR  almost-empty level, sampled every cycle
- `data_out`  out  WORD_SIZE  last word read (registered)
- `valid`  out  1  one-cycle pulse: `data_out` updated this cycle
- `empty`  out  1  count == 0
- `full`  out  1  count == MEM_SIZE
- `almost_empty`  out  1  count <= empty_threshold
- `almost_full`  out  1  count >= full_threshold
- `error`  out  1  one-cycle pulse on overflow or underflow attempt
- `count`  out  PTR+1  current occupancy, 0..MEM_SIZE

## Operation
- Storage: MEM_SIZE x WORD_SIZE register array; `wr_ptr`, `rd_ptr` are PTR bits and wrap MEM_SIZE-1 -> 0 naturally; `count` is PTR+1 bits.
- Write accepted iff `wr_enable && !full`: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff `rd_enable && !empty`: data_out <= mem[rd_ptr], rd_ptr++, valid <= 1; otherwise valid <= 0 and data_out holds.
- Count: +1 on write only, -1 on read only, unchanged when both or neither accepted.
- Simultaneous write and read:
  - With 1..MEM_SIZE-1 words, both are accepted.
  - When empty, only the write is accepted; the read flags underflow.
  - When full, only the read is accepted; the write flags overflow.
  - The FIFO never passes a word through in the same cycle.
- Overflow (`wr_enable && full`): word dropped, no state change except error <= 1.
- Underflow (`rd_enable && empty`): data_out holds, valid <= 0, error <= 1.
- If both overflow and underflow would occur in one cycle (impossible, since full and empty are exclusive), error is still a single pulse.
- Flags: `empty`, `full`, `almost_empty`, `almost_full` are combinational from `count` and threshold inputs; no extra register stage.
- Threshold corner cases are defined behaviour, not errors:
  - `full_threshold` = 0: `almost_full` is constant 1.
  - `empty_threshold` = 0: `almost_empty` equals `empty`.
- Threshold changes take effect combinationally in the same cycle. The control FSM changes them only in its INIT state, so no synchronisation is required.
- Reset (`reset` low, any time, including mid-transfer):
  - wr_ptr = rd_ptr = count = 0, data_out = 0, valid = 0, error = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1; almost_full = (full_threshold == 0).
  - Memory contents are not cleared and are unobservable.
  - Operation resumes on the first rising edge after `reset` returns high.

## Timing
- Write latency: a word written at edge k is readable by a read request sampled at edge k+1; `empty` falls right after edge k.
- Read latency: a read accepted at edge k makes `data_out`/`valid` valid after edge k; `valid` stays high for exactly one cycle unless consecutive reads are accepted.
- Back-to-back reads every cycle drain one word per cycle; back-to-back writes fill one word per cycle.
- `error` is registered: asserted during the cycle after the offending edge, for one cycle per offending edge.
- All outputs are glitch-free with respect to `clk` except the combinational flags, which settle within the cycle.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset then idle, thresholds 6/2 -> empty = 1, almost_empty = 1, full = 0, almost_full = 0, count = 0, error = 0, valid = 0.
- Write 0x101..0x108 on 8 consecutive cycles, thresholds 6/2 -> almost_empty falls when count = 3; almost_full rises at count = 6; full at count = 8. A 9th write of 0x1FF -> error pulse, count stays 8.
- From full, read 8 cycles -> data_out = 0x101..0x108 in order, valid high 8 cycles. Then empty = 1; a 9th read -> error pulse, data_out holds 0x108, valid = 0.
- Pointer wrap and simultaneous access:
  - Write 5, read 5, then simultaneously write and read for 10 cycles.
  - Required: count constant, data in FIFO order across the 7 -> 0 wrap, no error.
  - Same-cycle write and read with count = 0: only the write is accepted, error pulses, count = 1.
- Assert `reset` low asynchronously mid-burst (count = 4, between edges) -> outputs clear before the next edge. After release, a read gives error; a write then read returns the new word, not stale data.
- Threshold corners:
  - full_threshold = 0, empty_threshold = 0 -> almost_full = 1 at count = 0; almost_empty tracks empty.
  - full_threshold changed 6 -> 3 with count = 4 -> almost_full rises in the same cycle.

Source files
------------

// File: rtl/fifo_thresh.sv
// ============================================================================
// Module   : fifo_thresh
// Purpose  : 8 x 12-bit buffer FIFO with programmable almost-full/almost-empty
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_thresh #(
    parameter int WORD_SIZE = 12,
    parameter int MEM_SIZE  = 8,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_enable,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_enable,
    input  logic [PTR-1:0]       full_threshold,
    input  logic [PTR-1:0]       empty_threshold,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 error,
    output logic [PTR:0]         count
);

    localparam logic [PTR:0]   FULL_COUNT = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0]   CNT_ONE    = (PTR+1)'(1);
    localparam logic [PTR-1:0] PTR_ONE    = PTR'(1);

    logic [WORD_SIZE-1:0] mem [0:MEM_SIZE-1];
    logic [PTR-1:0]       wr_ptr;
    logic [PTR-1:0]       rd_ptr;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 overflow;
    logic                 underflow;

    // Flags come straight from the occupancy so threshold changes act at once.
    always_comb begin
        empty        = (count == '0);
        full         = (count == FULL_COUNT);
        almost_empty = (count <= {1'b0, empty_threshold});
        almost_full  = (count >= {1'b0, full_threshold});
    end

    always_comb begin
        wr_accept = wr_enable && !full;
        rd_accept = rd_enable && !empty;
        overflow  = wr_enable && full;
        underflow = rd_enable && empty;
    end

    // Storage is deliberately left out of reset; stale words are never readable
    // because the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            error <= overflow || underflow;
            valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_ONE;
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_thresh.sv
// ============================================================================
// Module   : tb_fifo_thresh
// Purpose  : self-checking bench for fifo_thresh against a queue-based model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_thresh;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_enable;
    logic [11:0] data_in;
    logic        rd_enable;
    logic [2:0]  full_threshold;
    logic [2:0]  empty_threshold;
    logic [11:0] data_out;
    logic        valid;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic        error;
    logic [3:0]  count;

    fifo_thresh dut (
        .clk             (clk),
        .reset           (reset),
        .wr_enable       (wr_enable),
        .data_in         (data_in),
        .rd_enable       (rd_enable),
        .full_threshold  (full_threshold),
        .empty_threshold (empty_threshold),
        .data_out        (data_out),
        .valid           (valid),
        .empty           (empty),
        .full            (full),
        .almost_empty    (almost_empty),
        .almost_full     (almost_full),
        .error           (error),
        .count           (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue plus the registered outputs.
    logic [11:0] m_q[$];
    logic [11:0] m_dout;
    logic        m_valid;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [11:0] din, input logic re);
        int n;
        n = m_q.size();
        m_err = (we && n == 8) || (re && n == 0);
        if (re && n != 0) begin
            m_dout  = m_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (we && n != 8) m_q.push_back(din);
    endtask

    task automatic check_all(input string ph);
        int n;
        n = m_q.size();
        check({ph, ".count"},    32'(count),        32'(n));
        check({ph, ".empty"},    32'(empty),        32'(n == 0));
        check({ph, ".full"},     32'(full),         32'(n == 8));
        check({ph, ".alm_empty"},32'(almost_empty), 32'(n <= int'(empty_threshold)));
        check({ph, ".alm_full"}, 32'(almost_full),  32'(n >= int'(full_threshold)));
        check({ph, ".valid"},    32'(valid),        32'(m_valid));
        check({ph, ".error"},    32'(error),        32'(m_err));
        check({ph, ".data_out"}, 32'(data_out),     32'(m_dout));
    endtask

    // One clock: drive, let the edge happen, update the model, compare.
    task automatic step(input string ph, input logic we, input logic [11:0] din, input logic re);
        wr_enable = we;
        data_in   = din;
        rd_enable = re;
        @(posedge clk);
        model_step(we, din, re);
        #1;
        check_all(ph);
    endtask

    // Asserts reset between edges and verifies the outputs clear immediately.
    task automatic async_reset(input string ph);
        #3;
        reset     = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        model_reset();
        #1;
        check_all({ph, ".async"});
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all({ph, ".release"});
    endtask

    initial begin
        reset           = 1'b0;
        wr_enable       = 1'b0;
        rd_enable       = 1'b0;
        data_in         = '0;
        full_threshold  = 3'd6;
        empty_threshold = 3'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("reset");
        step("idle", 1'b0, 12'h000, 1'b0);

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 12'(12'h100 + i), 1'b0);
        step("overflow", 1'b1, 12'h1FF, 1'b0);
        check("overflow.error_pulse", 32'(error), 32'd1);
        step("after_ovf", 1'b0, 12'h000, 1'b0);

        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, 12'h000, 1'b1);
            check("drain.order", 32'(data_out), 32'(12'h100 + i));
        end
        step("underflow", 1'b0, 12'h000, 1'b1);
        check("underflow.hold", 32'(data_out), 32'h108);

        for (int i = 0; i < 5; i++) step("w5", 1'b1, 12'(12'h200 + i), 1'b0);
        for (int i = 0; i < 5; i++) step("r5", 1'b0, 12'h000, 1'b1);
        step("w1", 1'b1, 12'h210, 1'b0);
        step("w2", 1'b1, 12'h211, 1'b0);
        for (int i = 0; i < 10; i++) step("simul", 1'b1, 12'(12'h220 + i), 1'b1);
        check("simul.count", 32'(count), 32'd2);
        step("r_a", 1'b0, 12'h000, 1'b1);
        step("r_b", 1'b0, 12'h000, 1'b1);
        step("simul_empty", 1'b1, 12'h2AA, 1'b1);
        check("simul_empty.count", 32'(count), 32'd1);
        step("r_c", 1'b0, 12'h000, 1'b1);

        for (int i = 0; i < 4; i++) step("burst", 1'b1, 12'(12'h300 + i), 1'b0);
        async_reset("midburst");
        step("post_rst_rd", 1'b0, 12'h000, 1'b1);
        step("post_rst_wr", 1'b1, 12'h3CC, 1'b0);
        step("post_rst_rd2", 1'b0, 12'h000, 1'b1);
        check("fresh_word", 32'(data_out), 32'h3CC);

        full_threshold  = 3'd0;
        empty_threshold = 3'd0;
        #1;
        check_all("thr0.empty");
        step("thr0.one", 1'b1, 12'h001, 1'b0);
        check("thr0.ae_eq_empty", 32'(almost_empty), 32'(empty));
        for (int i = 0; i < 3; i++) step("thr0.fill", 1'b1, 12'(12'h010 + i), 1'b0);
        full_threshold = 3'd6;
        #1;
        check("thr6.alm_full", 32'(almost_full), 32'd0);
        full_threshold = 3'd3;
        #1;
        check("thr3.alm_full", 32'(almost_full), 32'd1);

        for (int c = 0; c < 600; c++) begin
            logic we, re;
            int bias;
            if (c % 50 == 0) begin
                full_threshold  = 3'($urandom_range(0, 7));
                empty_threshold = 3'($urandom_range(0, 7));
            end
            bias = ((c / 80) % 2 == 0) ? 70 : 30;
            we = ($urandom_range(0, 99) < bias);
            re = ($urandom_range(0, 99) < (100 - bias));
            if ($urandom_range(0, 249) == 0) async_reset("rand");
            else step("rand", we, 12'($urandom), re);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
